six_sum_fifo: RTL and testbench

//   Result buffer placed directly downstream of the 6-bit ripple adder.

---
 rtl/six_sum_fifo_if.sv | 33 +++
 rtl/six_sum_fifo.sv | 75 +++++++
 tb/tb_six_sum_fifo.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/six_sum_fifo_if.sv
// Handshake bundle between the 6-bit adder, the result buffer and its consumer.
//   sclr                      synchronous flush request
//   in_valid/in_ready         producer handshake carrying in_sum/in_carry
//   out_valid/out_ready       consumer handshake carrying out_sum/out_carry
//   count, carry_count        buffer occupancy and saturating carry tally
// The buffer connects through the slave modport; stimulus/consumers use master.
interface six_sum_fifo_if #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4,
    parameter int CW    = 8
);
    logic                     sclr;
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         in_sum;
    logic                     in_carry;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_sum;
    logic                     out_carry;
    logic [$clog2(DEPTH):0]   count;
    logic [CW-1:0]            carry_count;

    modport master (
        output sclr, in_valid, in_sum, in_carry, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, count, carry_count
    );

    modport slave (
        input  sclr, in_valid, in_sum, in_carry, out_ready,
        output in_ready, out_valid, out_sum, out_carry, count, carry_count
    );
endinterface

// File: rtl/six_sum_fifo.sv
// Result buffer behind the 6-bit ripple adder. Stores {carry, sum} pairs in
// arrival order for a slower consumer and keeps a saturating tally of accepted
// results whose carry-out was set.
//   clk   rising-edge clock
//   rst   asynchronous active-high reset; discards all held entries
//   bus   six_sum_fifo_if.slave: sclr, input/output handshakes, count, carry_count
module six_sum_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    six_sum_fifo_if.slave bus
);
    localparam int             AW   = $clog2(DEPTH);
    localparam logic [AW:0]    FULL = (AW+1)'(DEPTH);

    logic [WIDTH:0]  mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count_q;
    logic [CW-1:0]   carry_q;
    logic [WIDTH:0]  head;
    logic            push;
    logic            pop;

    // Full blocks pushes even if the head is leaving this cycle.
    assign bus.in_ready  = (count_q != FULL);
    assign bus.out_valid = (count_q != '0);
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    assign head          = mem[rd_ptr];
    assign bus.out_sum   = bus.out_valid ? head[WIDTH-1:0] : '0;
    assign bus.out_carry = bus.out_valid ? head[WIDTH]     : 1'b0;
    assign bus.count       = count_q;
    assign bus.carry_count = carry_q;

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push && !bus.sclr) begin
            mem[wr_ptr] <= {bus.in_carry, bus.in_sum};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            carry_q <= '0;
        end else if (bus.sclr) begin
            // Flush wins over any push/pop; the tally is kept.
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (bus.in_carry && (carry_q != '1)) begin
                    carry_q <= carry_q + CW'(1);
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end
endmodule

// File: tb/tb_six_sum_fifo.sv
// Directed bench for six_sum_fifo: inputs change 1ns after the rising edge,
// outputs are checked in the same window before the next edge.
module tb_six_sum_fifo;
    logic clk;
    logic rst;
    int   tests_run;
    int   fails;

    six_sum_fifo_if #(.WIDTH(6), .DEPTH(4), .CW(8)) bus ();

    six_sum_fifo #(.WIDTH(6), .DEPTH(4), .CW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input int s, input bit c);
        bus.in_valid = 1'b1;
        bus.in_sum   = 6'(s);
        bus.in_carry = c;
        step();
        bus.in_valid = 1'b0;
        bus.in_carry = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.sclr = 1'b0; bus.in_valid = 1'b0; bus.in_sum = '0;
        bus.in_carry = 1'b0; bus.out_ready = 1'b0;
        step(); step();
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.count !== 3'd0 ||
            bus.carry_count !== 8'd0 || bus.out_sum !== 6'd0 || bus.out_carry !== 1'b0) begin
            fails++;
            $display("FAIL reset: got v=%b r=%b cnt=%0d cc=%0d s=%0d c=%b expected v=0 r=1 cnt=0 cc=0 s=0 c=0",
                     bus.out_valid, bus.in_ready, bus.count, bus.carry_count, bus.out_sum, bus.out_carry);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        push_one(21, 1'b0);
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== 6'd21 || bus.out_carry !== 1'b0 || bus.count !== 3'd1) begin
            fails++;
            $display("FAIL single_push: got v=%b s=%0d c=%b cnt=%0d expected v=1 s=21 c=0 cnt=1",
                     bus.out_valid, bus.out_sum, bus.out_carry, bus.count);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        tests_run++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_sum !== 6'd0) begin
            fails++;
            $display("FAIL single_drain: got cnt=%0d v=%b s=%0d expected cnt=0 v=0 s=0",
                     bus.count, bus.out_valid, bus.out_sum);
        end
        // Popping while empty must not underflow.
        bus.out_ready = 1'b1;
        step(); step();
        bus.out_ready = 1'b0;
        tests_run++;
        if (bus.count !== 3'd0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL empty_pop: got cnt=%0d r=%b expected cnt=0 r=1", bus.count, bus.in_ready);
        end
    endtask

    task automatic test_fill();
        int exp_s[4] = '{0, 5, 9, 12};
        int exp_c[4] = '{1, 0, 0, 0};
        push_one(0, 1'b1);   // 63+1 wraps to sum 0 with carry
        push_one(5, 1'b0);
        push_one(9, 1'b0);
        push_one(12, 1'b0);
        tests_run++;
        if (bus.count !== 3'd4 || bus.in_ready !== 1'b0 || bus.carry_count !== 8'd1) begin
            fails++;
            $display("FAIL fill: got cnt=%0d r=%b cc=%0d expected cnt=4 r=0 cc=1",
                     bus.count, bus.in_ready, bus.carry_count);
        end
        push_one(33, 1'b1);  // must be ignored, carry not tallied
        tests_run++;
        if (bus.count !== 3'd4 || bus.carry_count !== 8'd1) begin
            fails++;
            $display("FAIL full_push_ignored: got cnt=%0d cc=%0d expected cnt=4 cc=1",
                     bus.count, bus.carry_count);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out_sum !== 6'(exp_s[i]) || bus.out_carry !== 1'(exp_c[i])) begin
                fails++;
                $display("FAIL fill_drain[%0d]: got v=%b s=%0d c=%b expected v=1 s=%0d c=%0d",
                         i, bus.out_valid, bus.out_sum, bus.out_carry, exp_s[i], exp_c[i]);
            end
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
        end
        tests_run++;
        if (bus.count !== 3'd0) begin
            fails++;
            $display("FAIL fill_empty: got cnt=%0d expected 0", bus.count);
        end
    endtask

    task automatic test_full_simul();
        int exp_s[4] = '{2, 3, 4, 7};
        for (int i = 1; i <= 4; i++) push_one(i, 1'b0);
        bus.in_valid = 1'b1; bus.in_sum = 6'd7; bus.in_carry = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        tests_run++;
        if (bus.count !== 3'd3 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL full_simul_pop: got cnt=%0d r=%b expected cnt=3 r=1", bus.count, bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
        tests_run++;
        if (bus.count !== 3'd4) begin
            fails++;
            $display("FAIL full_simul_push: got cnt=%0d expected 4", bus.count);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (bus.out_sum !== 6'(exp_s[i])) begin
                fails++;
                $display("FAIL full_simul_order[%0d]: got s=%0d expected %0d", i, bus.out_sum, exp_s[i]);
            end
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        push_one(10, 1'b0);
        push_one(11, 1'b0);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_carry  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.in_sum = 6'(12 + i);
            tests_run++;
            if (bus.count !== 3'd2 || bus.out_sum !== 6'(10 + i)) begin
                fails++;
                $display("FAIL back_to_back[%0d]: got cnt=%0d s=%0d expected cnt=2 s=%0d",
                         i, bus.count, bus.out_sum, 10 + i);
            end
            step();
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (bus.out_sum !== 6'(20 + i)) begin
                fails++;
                $display("FAIL back_to_back_tail[%0d]: got s=%0d expected %0d", i, bus.out_sum, 20 + i);
            end
            step();
        end
        bus.out_ready = 1'b0;
        tests_run++;
        if (bus.count !== 3'd0) begin
            fails++;
            $display("FAIL back_to_back_empty: got cnt=%0d expected 0", bus.count);
        end
    endtask

    task automatic test_sclr();
        for (int i = 1; i <= 3; i++) push_one(i, 1'b0);
        tests_run++;
        if (bus.count !== 3'd3) begin
            fails++;
            $display("FAIL sclr_pre: got cnt=%0d expected 3", bus.count);
        end
        bus.sclr = 1'b1;
        push_one(9, 1'b1);   // discarded and not tallied
        bus.sclr = 1'b0;
        tests_run++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.carry_count !== 8'd1 || bus.out_sum !== 6'd0) begin
            fails++;
            $display("FAIL sclr: got cnt=%0d v=%b cc=%0d s=%0d expected cnt=0 v=0 cc=1 s=0",
                     bus.count, bus.out_valid, bus.carry_count, bus.out_sum);
        end
        push_one(5, 1'b0);
        tests_run++;
        if (bus.count !== 3'd1 || bus.out_sum !== 6'd5) begin
            fails++;
            $display("FAIL sclr_after_push: got cnt=%0d s=%0d expected cnt=1 s=5", bus.count, bus.out_sum);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_carry_sat();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_carry  = 1'b1;
        for (int i = 0; i < 300; i++) begin
            bus.in_sum = 6'(i);
            step();
            if (i == 199) begin
                tests_run++;
                if (bus.carry_count !== 8'd201) begin
                    fails++;
                    $display("FAIL carry_mid: got cc=%0d expected 201", bus.carry_count);
                end
            end
        end
        bus.in_valid = 1'b0;
        bus.in_carry = 1'b0;
        step();
        bus.out_ready = 1'b0;
        tests_run++;
        if (bus.carry_count !== 8'd255 || bus.count !== 3'd0) begin
            fails++;
            $display("FAIL carry_sat: got cc=%0d cnt=%0d expected cc=255 cnt=0", bus.carry_count, bus.count);
        end
    endtask

    task automatic test_rst_mid();
        push_one(17, 1'b1);
        push_one(18, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
            bus.carry_count !== 8'd0 || bus.out_sum !== 6'd0 || bus.out_carry !== 1'b0) begin
            fails++;
            $display("FAIL rst_async: got cnt=%0d v=%b r=%b cc=%0d s=%0d c=%b expected cnt=0 v=0 r=1 cc=0 s=0 c=0",
                     bus.count, bus.out_valid, bus.in_ready, bus.carry_count, bus.out_sum, bus.out_carry);
        end
        step();
        rst = 1'b0;
        step();
        push_one(42, 1'b1);
        tests_run++;
        if (bus.count !== 3'd1 || bus.out_sum !== 6'd42 || bus.out_carry !== 1'b1 || bus.carry_count !== 8'd1) begin
            fails++;
            $display("FAIL rst_recover: got cnt=%0d s=%0d c=%b cc=%0d expected cnt=1 s=42 c=1 cc=1",
                     bus.count, bus.out_sum, bus.out_carry, bus.carry_count);
        end
    endtask

    initial begin
        tests_run = 0;
        fails     = 0;
        test_reset();
        test_single();
        test_fill();
        test_full_simul();
        test_back_to_back();
        test_sclr();
        test_carry_sat();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
